// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: FSM state encoding and default byte width.
// The same encoding is used by the Rx and Tx sequencers.
package uart_defs;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } uart_state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req     : per-requester pending level
//   ptr     : index of the last served requester
//   win     : one-hot winner (zero when req == 0)
//   win_idx : binary index of the winner
// The search starts at ptr+1 and wraps, so the last owner has lowest priority.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] win,
  output logic [IW-1:0]    win_idx
);
  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        found      = 1'b1;
        win[cand]  = 1'b1;
        win_idx    = cand;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmitter among N_REQ
// byte sources, holding the grant across a packet until its last byte.
//   clk, n_rst   : clock, async active-low reset
//   req/last     : per-requester byte-pending level / final-byte flag
//   data_in      : packed byte slices, slice i = data_in[i*DATA_W +: DATA_W]
//   tx_busy      : UART Tx frame in progress
//   tx_start     : one-cycle load pulse, tx_data : registered byte
//   ack          : one-cycle consume pulse per requester
//   grant        : one-hot owner, grant_valid = |grant
//   err_timeout  : tx_busy failed to rise within BUSY_TIMEOUT cycles
module uart_tx_arbiter
  import uart_defs::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        last,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        grant,
  output logic                    grant_valid,
  output logic                    err_timeout
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  uart_state_t       state, state_n;
  logic [N_REQ-1:0]  grant_n;
  logic [IW-1:0]     gidx, gidx_n, ptr, ptr_n;
  logic [DATA_W-1:0] tx_data_n;
  logic              last_q, last_n, err_n;
  logic [CW-1:0]     cnt, cnt_n, cnt_inc;

  logic [N_REQ-1:0]  win;
  logic [IW-1:0]     win_idx, sel_idx;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  // IDLE loads the fresh winner; WAIT_DONE reloads from the current owner.
  assign sel_idx  = (state == IDLE) ? win_idx : gidx;
  assign sel_data = data_in[int'(sel_idx)*DATA_W +: DATA_W];
  assign sel_last = last[sel_idx];
  assign cnt_inc  = (cnt == CW'(BUSY_TIMEOUT)) ? cnt : cnt + 1'b1;

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    gidx_n    = gidx;
    ptr_n     = ptr;
    tx_data_n = tx_data;
    last_n    = last_q;
    cnt_n     = cnt;
    err_n     = 1'b0;
    case (state)
      IDLE: if (|req) begin
        grant_n   = win;
        gidx_n    = win_idx;
        tx_data_n = sel_data;
        last_n    = sel_last;
        state_n   = SEND;
      end
      SEND: begin
        cnt_n   = '0;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // busy on the final counting cycle still counts as success
        if (tx_busy) state_n = WAIT_DONE;
        else begin
          cnt_n = cnt_inc;
          if (cnt_inc == CW'(BUSY_TIMEOUT)) begin
            err_n   = 1'b1;
            ptr_n   = gidx;
            grant_n = '0;
            state_n = IDLE;
          end
        end
      end
      WAIT_DONE: if (!tx_busy) begin
        if (last_q || !req[gidx]) begin
          ptr_n   = gidx;
          grant_n = '0;
          state_n = IDLE;
        end else begin
          tx_data_n = sel_data;
          last_n    = sel_last;
          state_n   = SEND;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      grant       <= '0;
      gidx        <= '0;
      ptr         <= IW'(N_REQ - 1);
      tx_data     <= '0;
      last_q      <= 1'b0;
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      gidx        <= gidx_n;
      ptr         <= ptr_n;
      tx_data     <= tx_data_n;
      last_q      <= last_n;
      cnt         <= cnt_n;
      err_timeout <= err_n;
    end
  end

  assign tx_start    = (state == SEND);
  assign ack         = (state == SEND) ? grant : '0;
  assign grant_valid = |grant;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues drive the
// DUT, a packet-level model predicts the order of transmitted bytes, and a
// negedge monitor compares each tx_start against the predicted sequence.
module tb_uart_tx_arbiter;
  localparam int N_REQ = 4;
  localparam int DATA_W = 8;
  localparam int BUSY_TIMEOUT = 16;

  logic                    clk = 1'b0;
  logic                    n_rst = 1'b0;
  logic [N_REQ-1:0]        req = '0;
  logic [N_REQ-1:0]        last = '0;
  logic [N_REQ*DATA_W-1:0] data_in = '0;
  logic                    tx_busy = 1'b0;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic [N_REQ-1:0]        ack;
  logic [N_REQ-1:0]        grant;
  logic                    grant_valid;
  logic                    err_timeout;

  uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .last(last), .data_in(data_in),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .ack(ack),
    .grant(grant), .grant_valid(grant_valid), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct { int g; logic [7:0] d; } exp_t;
  exp_t       exp_q[$];
  logic [8:0] rq [N_REQ][$];   // {last, data} per pending byte
  int checks = 0, errors = 0, cyc = 0;
  int mptr = N_REQ - 1;
  int exp_err_cyc = -1;
  bit never_busy = 1'b0;
  bit pend = 1'b0;
  int dly = 0, blen = 0, nlen = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void drive_inputs();
    for (int i = 0; i < N_REQ; i++) begin
      req[i] = (rq[i].size() != 0);
      if (rq[i].size() != 0) begin
        data_in[i*DATA_W +: DATA_W] = rq[i][0][7:0];
        last[i] = rq[i][0][8];
      end else last[i] = 1'b0;
    end
  endfunction

  // Packet-level model: serve owners round-robin, each owner sends bytes
  // until one carries last or its queue runs dry.
  function automatic void predict();
    logic [8:0] m [N_REQ][$];
    logic [8:0] b;
    exp_t e;
    int g;
    bit any;
    for (int i = 0; i < N_REQ; i++) m[i] = rq[i];
    while (1) begin
      any = 1'b0;
      g = 0;
      for (int k = 1; k <= N_REQ; k++) begin
        int i = (mptr + k) % N_REQ;
        if (!any && m[i].size() != 0) begin any = 1'b1; g = i; end
      end
      if (!any) break;
      do begin
        b = m[g].pop_front();
        e.g = g; e.d = b[7:0];
        exp_q.push_back(e);
      end while (!b[8] && m[g].size() != 0);
      mptr = g;
    end
  endfunction

  // requesters: consume on ack, present next byte
  always @(posedge clk) begin
    #2;
    if (n_rst)
      for (int i = 0; i < N_REQ; i++)
        if (ack[i] && rq[i].size() != 0) void'(rq[i].pop_front());
    drive_inputs();
  end

  // UART Tx model: busy rises 1..3 cycles after start, lasts 1..4 cycles
  always @(posedge clk) begin
    #2;
    if (tx_busy) begin
      blen--;
      if (blen <= 0) tx_busy = 1'b0;
    end else if (pend) begin
      if (dly == 0) begin tx_busy = 1'b1; blen = nlen; pend = 1'b0; end
      else dly--;
    end
    if (tx_start && !never_busy) begin
      pend = 1'b1;
      dly  = $urandom_range(0, 2);
      nlen = $urandom_range(1, 4);
    end
  end

  // monitor / scoreboard
  logic [N_REQ-1:0] pgrant, preq;
  bit pvalid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!n_rst) pvalid = 1'b0;
    else begin
      chk("grant_valid", grant_valid, |grant);
      chk("grant_onehot", $countones(grant) <= 1, 1);
      if (pvalid) begin
        if (pgrant == 0 && preq != 0) chk("grant_after_idle", grant != 0, 1);
        if (pgrant != 0 && grant != 0) chk("grant_hold", grant, pgrant);
      end
      if (tx_start) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: got tx_data %0h grant %b, expected no start", tx_data, grant);
        end else begin
          e = exp_q.pop_front();
          chk("start_grant", grant, 1 << e.g);
          chk("start_data", tx_data, e.d);
          chk("start_ack", ack, 1 << e.g);
        end
        if (never_busy) exp_err_cyc = cyc + 17;
      end else if (ack != 0) chk("ack_outside_send", ack, 0);
      if (cyc == exp_err_cyc) begin
        chk("err_timeout", err_timeout, 1);
        chk("grant_after_timeout", grant, 0);
      end else if (err_timeout) chk("spurious_err_timeout", err_timeout, 0);
      pgrant = grant;
      preq = req;
      pvalid = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk); #3;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_grant_valid"}, grant_valid, 0);
    chk({tag, "_err"}, err_timeout, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
  endtask

  function automatic bit any_pending();
    bit p = (grant != 0) || tx_busy || pend || (exp_q.size() != 0) || (exp_err_cyc >= cyc);
    for (int i = 0; i < N_REQ; i++) if (rq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain(string tag);
    int n = 0;
    while (any_pending() && n < 3000) begin step(); n++; end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes still expected after %0d cycles, expected 0", tag, exp_q.size(), n);
      exp_q.delete();
    end
    repeat (2) step();
  endtask

  task automatic put(int i, logic [7:0] d, bit l);
    rq[i].push_back({l, d});
  endtask

  task automatic launch();
    predict();
    drive_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    step(); n_rst = 1'b1;
    repeat (2) step();
    check_zero("post_reset");

    // single byte from requester 2
    put(2, 8'h41, 1'b1); launch();
    wait_drain("single");

    // fairness: every requester, two single-byte packets
    for (int j = 0; j < 2; j++) for (int i = 0; i < N_REQ; i++) put(i, 8'hC0 + 8'(4*j + i), 1'b1);
    launch();
    wait_drain("fair");

    // packet hold: requester 1 three bytes while requester 0 waits
    put(1, 8'h10, 1'b0); put(1, 8'h11, 1'b0); put(1, 8'h12, 1'b1);
    put(0, 8'h55, 1'b1);
    launch();
    wait_drain("packet");

    // early drop after a non-last byte
    put(3, 8'hA0, 1'b0); launch();
    wait_drain("drop");

    // busy never rises
    never_busy = 1'b1;
    put(1, 8'h77, 1'b1); launch();
    wait_drain("timeout");
    never_busy = 1'b0;

    // randomized batches
    for (int b = 0; b < 15; b++) begin
      for (int i = 0; i < N_REQ; i++) begin
        n = $urandom_range(0, 4);
        for (int j = 0; j < n; j++) begin
          r = $urandom();
          put(i, r[7:0], r[9:8] == 2'b00);
        end
      end
      launch();
      wait_drain("random");
    end

    // reset in the middle of a packet
    put(2, 8'h21, 1'b0); put(2, 8'h22, 1'b0); put(2, 8'h23, 1'b1);
    launch();
    n = 0;
    while (!(grant != 0 && tx_busy) && n < 200) begin step(); n++; end
    chk("reach_mid_frame", n < 200, 1);
    n_rst = 1'b0;
    #1;
    check_zero("midreset");
    for (int i = 0; i < N_REQ; i++) rq[i].delete();
    exp_q.delete();
    exp_err_cyc = -1;
    mptr = N_REQ - 1;
    drive_inputs();
    repeat (2) step();
    n_rst = 1'b1;
    n = 0;
    while ((tx_busy || pend) && n < 50) begin step(); n++; end
    put(3, 8'h33, 1'b1); put(0, 8'h30, 1'b1);
    launch();
    wait_drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among `N_REQ` byte sources, such as the MIPS core, a debug monitor and an Rx echo path. It grants one requester at a time and loads that requester's byte into the transmitter with a start pulse. It tracks the transmitter's busy flag and holds the grant across multi-byte packets until the requester marks its last byte. The block sits between the requester fabric and the UART Tx datapath, mirroring how the Rx side is sequenced by its FSM.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 8, byte width
- `BUSY_TIMEOUT`, 16, clk cycles allowed for `tx_busy` to rise after `tx_start`
- `clk` in 1: single clock, all state on rising edge
- `n_rst` in 1: reset, asynchronous, active-low
- `req` in N_REQ: per-requester byte-pending level
- `last` in N_REQ: byte on `data_in` slice is final byte of packet
- `data_in` in N_REQ*DATA_W: slice i = `data_in[i*DATA_W +: DATA_W]`; held stable while `req[i]` is high and unacknowledged
- `tx_busy` in 1: UART Tx frame in progress
- `tx_start` out 1: one-cycle load pulse to UART Tx
- `tx_data` out DATA_W: registered byte to UART Tx
- `ack` out N_REQ: one-cycle pulse, byte of requester i consumed
- `grant` out N_REQ: one-hot current owner, all-zero when idle
- `grant_valid` out 1: OR of `grant`
- `err_timeout` out 1: one-cycle pulse, `tx_busy` never rose

## Operation
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE: if `req` != 0, select the winner by searching from index `ptr+1` upward with wrap. On the next edge:
  - `grant` is set.
  - `tx_data` loads the winner's slice.
  - `last_q` captures `last[g]`.
  - The state moves to SEND.
- SEND (exactly 1 cycle): `tx_start`=1 and `ack[g]`=1. Clear the timeout counter. Next state is WAIT_BUSY.
- WAIT_BUSY:
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches `BUSY_TIMEOUT`, pulse `err_timeout`, set `ptr`=g, clear `grant` and go to IDLE.
- WAIT_DONE: wait for `tx_busy`=0. In that cycle:
  - If `last_q`=1 or `req[g]`=0, release: `ptr`=g, clear `grant`, go to IDLE.
  - Otherwise reload `tx_data` and `last_q` from requester g and go to SEND. The grant is held and no re-arbitration takes place.
- Round-robin pointer: `ptr` resets to N_REQ-1, so index 0 has first priority. It updates only on release or timeout.
- Requests arriving while the grant is held are queued by level only; nothing is latched.
- Counter width is clog2(BUSY_TIMEOUT+1). It saturates and never wraps.

## Timing
- Reset values: state IDLE.
  - `tx_start`, `ack`, `grant`, `grant_valid`, `err_timeout` = 0.
  - `tx_data` = 0, `ptr` = N_REQ-1, counter 0.
- Reset mid-operation: an in-flight byte is abandoned. No `ack` is issued after reset deasserts, and the UART Tx finishes on its own.
- Latency: `req` is sampled high in IDLE at cycle 0.
  - `grant` and `tx_data` are valid at cycle 1.
  - `tx_start` and `ack` are at cycle 1.
  - The earliest `tx_busy` is sampled at cycle 2.
- The requester may change `data_in` and `last` in the cycle after `ack`. It may drop `req` after `ack` to end the packet.
- Back-to-back bytes of a packet go out with `tx_busy` falling at cycle t, then the next `tx_start` at t+1.
- Release then re-grant: at least 1 IDLE cycle between owners.
- Simultaneous events:
  - `req[g]` falling in the same cycle as `tx_busy` falls means release.
  - `tx_busy` rising on the exact timeout cycle means success; busy takes priority.
- `tx_data` holds its value between loads. `tx_start` and `ack` are never asserted outside SEND.

## Structure
- Shared `uart_defs` package/include: the state encoding constants (IDLE=2'd0, SEND=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3) and the default `DATA_W`. Both are reused by the Rx FSM and the Tx FSM.
- One sub-module: `rr_pick`. It is combinational, taking `req` and `ptr` and producing a one-hot winner plus its index, parameterised by N_REQ.
- The FSM, timeout counter, data mux and output registers live in the top module.

## Test plan
- Single byte: `req[2]`=1, `last[2]`=1, data 8'h41, with Tx model busy 3 cycles after start.
  - Expect `grant`=4'b0100, one `tx_start`, `tx_data`=8'h41 and `ack[2]` at cycle 1.
  - Expect release and `ptr`=2.
- Fairness: `req`=4'b1111 held, every byte `last`=1.
  - Expect grant order 0,1,2,3,0.
  - Expect exactly 1 IDLE cycle between grants.
- Packet hold: `req[1]` sends 3 bytes 8'h10, 8'h11, 8'h12 with `last` on the third, while `req[0]` is also high.
  - Expect 3 consecutive `tx_start` with `grant` held at 4'b0010 throughout, then a grant to 0.
- Early drop: `req[3]` drops after the first `ack` of a non-last byte.
  - Expect release on `tx_busy` falling, and no second `tx_start`.
- Timeout: Tx model never asserts busy.
  - Expect `err_timeout` pulse 16 cycles after WAIT_BUSY entry, then `grant`=0 and state IDLE.
- Reset mid-frame: drop `n_rst` during WAIT_DONE.
  - Expect all outputs 0 immediately.
  - Expect next grant to index 0.
